mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between two requesters.
  - Port 0: the multicycle CPU (the control unit's MemRead/MemWrite/IorD path).
  - Port 1: a debug/program-loader master.
- Serialises accesses, drives the memory for a parameterised fixed latency, and returns read data with a one-cycle ack.
- CPU has default priority, bounded by a starvation limit so the loader always progresses.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single unified memory port: serialises CPU and
// debug-loader accesses, waits a fixed memory latency, and returns read data with an ack.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MEM_LAT        = 1,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [3:0]      wait_cnt_reg;
  logic [3:0]      streak_reg;
  logic            owner_reg;
  logic            we_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW-1:0]   cpu_rdata_reg;
  logic [DW-1:0]   dbg_rdata_reg;
  logic            grant_cpu;
  logic            grant_dbg;
  logic            last_wait;

  // CPU wins by default; debug is forced once the CPU has won MAX_CPU_STREAK contested rounds.
  assign grant_cpu = cpu_req && (!dbg_req || (streak_reg != 4'(MAX_CPU_STREAK)));
  assign grant_dbg = dbg_req && !grant_cpu;
  assign last_wait = (wait_cnt_reg == 4'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (cpu_req || dbg_req) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (last_wait) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt_reg  <= '0;
      streak_reg    <= '0;
      owner_reg     <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cpu_rdata_reg <= '0;
      dbg_rdata_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_cpu) begin
            owner_reg  <= 1'b0;
            we_reg     <= cpu_we;
            addr_reg   <= cpu_addr;
            wdata_reg  <= cpu_wdata;
            // A contested CPU win cannot overflow: at the limit debug would have won instead.
            streak_reg <= dbg_req ? streak_reg + 4'd1 : 4'd0;
          end else if (grant_dbg) begin
            owner_reg  <= 1'b1;
            we_reg     <= dbg_we;
            addr_reg   <= dbg_addr;
            wdata_reg  <= dbg_wdata;
            streak_reg <= 4'd0;
          end
        end
        S_ISSUE: begin
          wait_cnt_reg <= 4'(MEM_LAT);
        end
        S_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (last_wait && !we_reg) begin
            if (owner_reg) begin
              dbg_rdata_reg <= mem_rdata;
            end else begin
              cpu_rdata_reg <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_en    = (state_reg == S_ISSUE);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg != S_IDLE);
  assign owner     = owner_reg;
  assign cpu_ack   = (state_reg == S_DONE) && !owner_reg;
  assign dbg_ack   = (state_reg == S_DONE) && owner_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dbg_rdata = dbg_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance with a small word memory,
// plus a MEM_LAT=1 instance for back-to-back throughput.
module tb_mem_port_arbiter;

  logic        clk;
  logic        nrst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, busy, owner;

  logic        b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_ack, b_dbg_ack, b_mem_en, b_mem_we, b_busy, b_owner;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_CPU_STREAK(4)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_CPU_STREAK(4)) dut_b (
    .clk(clk), .nrst(nrst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_rdata(b_dbg_rdata), .dbg_ack(b_dbg_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: read data follows the address of the last strobe and holds until the next one.
  logic [31:0] mem_arr [0:255];
  logic [7:0]  rd_idx;
  always @(posedge clk) begin
    if (!nrst) begin
      mem_arr[0]  <= 32'h1111_1111;
      mem_arr[1]  <= 32'h2222_2222;
      mem_arr[16] <= 32'hDEAD_BEEF;
      mem_arr[64] <= 32'h0000_0000;
      rd_idx      <= 8'd0;
    end else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
      rd_idx <= mem_addr[9:2];
    end
  end
  assign mem_rdata   = mem_arr[rd_idx];
  assign b_mem_rdata = b_mem_addr ^ 32'hCAFE_0000;

  typedef struct {
    logic        cr;
    logic [31:0] ca;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [4:0]  ctl;   // {mem_en, cpu_ack, dbg_ack, busy, owner}
    logic        xwe;
    logic [31:0] xaddr;
    logic [31:0] xwd;
    logic [31:0] xcrd;
    logic [31:0] xdrd;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(logic cr, logic [31:0] ca, logic dr, logic dw, logic [31:0] da,
                              logic [31:0] dd, logic [4:0] ctl, logic xwe, logic [31:0] xaddr,
                              logic [31:0] xwd, logic [31:0] xcrd, logic [31:0] xdrd);
    vec_t v;
    v.cr = cr; v.ca = ca; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ctl = ctl; v.xwe = xwe; v.xaddr = xaddr; v.xwd = xwd; v.xcrd = xcrd; v.xdrd = xdrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Waits for the next strobe and its ack, checking who was granted and the returned data.
  task automatic grant(input logic exp_dbg, input int idx);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_en && n < 20);
    chk($sformatf("grant%0d_strobe", idx), mem_en, 1);
    chk($sformatf("grant%0d_owner", idx), owner, exp_dbg);
    n = 0;
    do begin @(negedge clk); n++; end while (!(cpu_ack || dbg_ack) && n < 20);
    chk($sformatf("grant%0d_acks", idx), {cpu_ack, dbg_ack}, {!exp_dbg, exp_dbg});
    if (exp_dbg) chk($sformatf("grant%0d_dbg_rdata", idx), dbg_rdata, 32'h2222_2222);
    else         chk($sformatf("grant%0d_cpu_rdata", idx), cpu_rdata, 32'h1111_1111);
    $display("grant %0d: owner=%0d cpu_ack=%0d dbg_ack=%0d", idx, owner, cpu_ack, dbg_ack);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = 0; b_dbg_wdata = 0;

    vt[0]  = mk(1, 32'h40, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 32'h40, 0, 0, 0, 0, 5'b10010, 0, 32'h40, 0, 0, 0);
    vt[2]  = mk(1, 32'h80, 0, 0, 0, 0, 5'b00010, 0, 32'h40, 0, 0, 0);
    vt[3]  = mk(1, 32'h80, 0, 0, 0, 0, 5'b00010, 0, 32'h40, 0, 0, 0);
    vt[4]  = mk(0, 32'h80, 0, 0, 0, 0, 5'b01010, 0, 32'h40, 0, 32'hDEADBEEF, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 32'hDEADBEEF, 0);
    vt[6]  = mk(0, 0, 1, 1, 32'h100, 32'h12345678, 5'b00000, 0, 0, 0, 32'hDEADBEEF, 0);
    vt[7]  = mk(0, 0, 1, 1, 32'h100, 32'h12345678, 5'b10011, 1, 32'h100, 32'h12345678, 32'hDEADBEEF, 0);
    vt[8]  = mk(0, 0, 1, 1, 32'h100, 32'h12345678, 5'b00011, 1, 32'h100, 32'h12345678, 32'hDEADBEEF, 0);
    vt[9]  = mk(0, 0, 1, 1, 32'h100, 32'h12345678, 5'b00011, 1, 32'h100, 32'h12345678, 32'hDEADBEEF, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 5'b00111, 1, 32'h100, 32'h12345678, 32'hDEADBEEF, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 32'hDEADBEEF, 0);
    vt[12] = mk(0, 0, 1, 0, 32'h100, 0, 5'b00001, 0, 0, 0, 32'hDEADBEEF, 0);
    vt[13] = mk(0, 0, 1, 0, 32'h100, 0, 5'b10011, 0, 32'h100, 0, 32'hDEADBEEF, 0);
    vt[14] = mk(0, 0, 1, 0, 32'h100, 0, 5'b00011, 0, 32'h100, 0, 32'hDEADBEEF, 0);
    vt[15] = mk(0, 0, 1, 0, 32'h100, 0, 5'b00011, 0, 32'h100, 0, 32'hDEADBEEF, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 5'b00111, 0, 32'h100, 0, 32'hDEADBEEF, 32'h12345678);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 32'hDEADBEEF, 32'h12345678);

    repeat (3) @(negedge clk);
    chk("reset_ctl", {mem_en, cpu_ack, dbg_ack, busy, owner}, 5'b00000);
    chk("reset_bus", {mem_we, mem_addr, mem_wdata} == '0, 1);
    chk("reset_rdata", {cpu_rdata, dbg_rdata} == '0, 1);
    $display("reset: ctl=%b", {mem_en, cpu_ack, dbg_ack, busy, owner});
    nrst = 1'b1;

    // CPU read, debug write, debug read-back, one row per cycle
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      cpu_req = vt[i].cr; cpu_addr = vt[i].ca; cpu_we = 1'b0; cpu_wdata = 32'h0;
      dbg_req = vt[i].dr; dbg_we = vt[i].dw; dbg_addr = vt[i].da; dbg_wdata = vt[i].dd;
      chk($sformatf("row%0d_ctl", i), {mem_en, cpu_ack, dbg_ack, busy, owner}, vt[i].ctl);
      if (vt[i].ctl[1]) begin
        chk($sformatf("row%0d_mem_we", i), mem_we, vt[i].xwe);
        chk($sformatf("row%0d_mem_addr", i), mem_addr, vt[i].xaddr);
        chk($sformatf("row%0d_mem_wdata", i), mem_wdata, vt[i].xwd);
      end
      chk($sformatf("row%0d_cpu_rdata", i), cpu_rdata, vt[i].xcrd);
      chk($sformatf("row%0d_dbg_rdata", i), dbg_rdata, vt[i].xdrd);
      $display("row %0d: ctl=%b addr=%h cpu_rdata=%h dbg_rdata=%h",
               i, {mem_en, cpu_ack, dbg_ack, busy, owner}, mem_addr, cpu_rdata, dbg_rdata);
    end

    // Both held continuously: four CPU grants, then debug
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h4;
    for (int g = 0; g < 10; g++) grant((g % 5) == 4, g);
    cpu_req = 0; dbg_req = 0;

    // Uncontested CPU grants clear the streak
    @(negedge clk);
    cpu_req = 1; dbg_req = 1;
    grant(0, 10); grant(0, 11);
    dbg_req = 0;
    grant(0, 12); grant(0, 13); grant(0, 14);
    dbg_req = 1;
    grant(0, 15); grant(0, 16); grant(0, 17); grant(0, 18);
    grant(1, 19);
    cpu_req = 0; dbg_req = 0;

    // Reset during WAIT abandons the access and the streak
    @(negedge clk);
    cpu_req = 1; dbg_req = 1;
    grant(0, 20); grant(0, 21);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_en && n < 20);
      chk("rst_pre_strobe", mem_en, 1);
    end
    @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    nrst = 1'b0;
    #1;
    chk("rst_async_ctl", {mem_en, cpu_ack, dbg_ack, busy, owner}, 5'b00000);
    chk("rst_async_cpu_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    chk("rst_hold_ctl", {mem_en, cpu_ack, busy}, 3'b000);
    @(negedge clk);
    chk("rst_hold2_ctl", {mem_en, cpu_ack, busy}, 3'b000);
    nrst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_rel%0d_mem_en", k), mem_en, (k == 1));
      chk($sformatf("rst_rel%0d_cpu_ack", k), cpu_ack, (k == 4));
      chk($sformatf("rst_rel%0d_dbg_ack", k), dbg_ack, 0);
      $display("release+%0d: mem_en=%0d cpu_ack=%0d", k, mem_en, cpu_ack);
    end
    chk("rst_reissue_rdata", cpu_rdata, 32'h1111_1111);
    grant(0, 22); grant(0, 23); grant(0, 24);
    grant(1, 25);
    cpu_req = 0; dbg_req = 0;

    // MEM_LAT=1 back-to-back CPU reads: one strobe and one ack every 4 cycles
    @(negedge clk);
    b_cpu_req = 1; b_cpu_addr = 32'h20;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("b2b_c%0d_mem_en", c), b_mem_en, (c % 4) == 1);
      chk($sformatf("b2b_c%0d_cpu_ack", c), b_cpu_ack, (c % 4) == 3);
      chk($sformatf("b2b_c%0d_busy", c), b_busy, (c % 4) != 0);
      chk($sformatf("b2b_c%0d_dbg_ack", c), {b_dbg_ack, b_owner}, 2'b00);
      if ((c % 4) == 1) chk($sformatf("b2b_c%0d_bus", c), {b_mem_we, b_mem_addr, b_mem_wdata},
                            {1'b0, 32'h20, 32'h0});
      if ((c % 4) == 3) chk($sformatf("b2b_c%0d_rdata", c), b_cpu_rdata, 32'hCAFE_0020);
      $display("b2b cycle %0d: mem_en=%0d cpu_ack=%0d busy=%0d", c, b_mem_en, b_cpu_ack, b_busy);
    end
    b_cpu_req = 0;
    chk("b2b_dbg_rdata", b_dbg_rdata, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
